// File: rtl/skein_result_checker.sv
// skein_result_checker
// Back end of the Skein-512 hash pipeline: checks the final 64-bit hash word
// against a difficulty target, recovers the originating nonce and queues the
// winners in a small FIFO drained through a valid/ready handshake.
// Optional feature macro: SKEIN_CHECK_HASHWORD_EN (adds out_word, the stored
// hash word presented alongside out_nonce).
module skein_result_checker #(
  parameter logic [31:0] NONCE_OFFSET = 32'd54,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] hash,
  input  logic         hash_vld,
  input  logic [31:0]  nonce,
  input  logic [63:0]  target,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_nonce,
`ifdef SKEIN_CHECK_HASHWORD_EN
  output logic [63:0]  out_word,
`endif
  output logic [31:0]  hash_count,
  output logic         overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef SKEIN_CHECK_HASHWORD_EN
  localparam int EW = 96;
`else
  localparam int EW = 32;
`endif

  // S0 sample registers
  logic          s0_vld_q;
  logic [63:0]   s0_cand_q;
  logic [63:0]   s0_tgt_q;
  logic [31:0]   s0_n_q;

  // FIFO state
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Output / status registers
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_nonce_q;
  logic [31:0]   hash_count_q;
  logic          overflow_q;
`ifdef SKEIN_CHECK_HASHWORD_EN
  logic [63:0]   out_word_q;
`endif

  // Combinational helpers
  logic          match_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_en_s;
  logic          drop_s;
  logic [CW-1:0] avail_s;
  logic [EW-1:0] entry_s;
  logic [EW-1:0] head_s;

  // S0: capture the candidate word, the target and the recovered nonce
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_vld_q  <= 1'b0;
      s0_cand_q <= 64'd0;
      s0_tgt_q  <= 64'd0;
      s0_n_q    <= 32'd0;
    end else begin
      s0_vld_q <= hash_vld;
      if (hash_vld) begin
        s0_cand_q <= hash[63:0];
        s0_tgt_q  <= target;
        s0_n_q    <= nonce - NONCE_OFFSET;
      end else begin
        s0_cand_q <= s0_cand_q;
        s0_tgt_q  <= s0_tgt_q;
        s0_n_q    <= s0_n_q;
      end
    end
  end

  // S1 compare, FIFO push/pop decisions and next output state
  always_comb begin
    match_s  = 1'b0;
    if (s0_vld_q) begin
      match_s = (s0_cand_q <= s0_tgt_q);
    end else begin
      match_s = 1'b0;
    end
    pop_s    = out_valid_q & out_ready;
    full_s   = (count_q == DEPTH_C);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    wr_en_s  = match_s & (~full_s | pop_s);
    drop_s   = match_s & full_s & ~pop_s;
    wr_ptr_d = wr_en_s ? wr_ptr_q + {{(PW-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop_s   ? rd_ptr_q + {{(PW-1){1'b0}}, 1'b1} : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    // The output register looks at entries already stored before this edge,
    // skipping the head when it is being popped; this gives bubble-free drain.
    avail_s     = count_q - {{(CW-1){1'b0}}, pop_s};
    out_valid_d = (avail_s != {CW{1'b0}});
    head_s      = mem_q[rd_ptr_d];
`ifdef SKEIN_CHECK_HASHWORD_EN
    entry_s = {s0_cand_q, s0_n_q};
`else
    entry_s = s0_n_q;
`endif
  end

  // FIFO storage write (no reset needed: contents are qualified by count)
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  // FIFO pointers, occupancy, counters, sticky overflow and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
      out_valid_q  <= 1'b0;
      out_nonce_q  <= 32'd0;
      hash_count_q <= 32'd0;
      overflow_q   <= 1'b0;
`ifdef SKEIN_CHECK_HASHWORD_EN
      out_word_q   <= 64'd0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      hash_count_q <= s0_vld_q ? hash_count_q + 32'd1 : hash_count_q;
      overflow_q   <= overflow_q | drop_s;
      if (out_valid_d) begin
        out_nonce_q <= head_s[31:0];
`ifdef SKEIN_CHECK_HASHWORD_EN
        out_word_q  <= head_s[95:32];
`endif
      end else begin
        out_nonce_q <= out_nonce_q;
`ifdef SKEIN_CHECK_HASHWORD_EN
        out_word_q  <= out_word_q;
`endif
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_nonce  = out_nonce_q;
  assign hash_count = hash_count_q;
  assign overflow   = overflow_q;
`ifdef SKEIN_CHECK_HASHWORD_EN
  assign out_word   = out_word_q;
`endif

endmodule

// File: tb/tb_skein_result_checker.sv
// Directed testbench for skein_result_checker with a nonce scoreboard.
module tb_skein_result_checker;

  localparam logic [31:0] OFFS  = 32'd54;
  localparam int          DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] hash;
  logic         hash_vld;
  logic [31:0]  nonce;
  logic [63:0]  target;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_nonce;
  logic [31:0]  hash_count;
  logic         overflow;
`ifdef SKEIN_CHECK_HASHWORD_EN
  logic [63:0]  out_word;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_count;

  skein_result_checker #(.NONCE_OFFSET(OFFS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .hash(hash), .hash_vld(hash_vld),
    .nonce(nonce), .target(target), .out_valid(out_valid),
    .out_ready(out_ready), .out_nonce(out_nonce),
`ifdef SKEIN_CHECK_HASHWORD_EN
    .out_word(out_word),
`endif
    .hash_count(hash_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a handshake seen mid-cycle means the head leaves on the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {32'd0, out_nonce}, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        chk("out_nonce", {32'd0, out_nonce}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One hash_vld pulse followed by one idle cycle (2-cycle spacing).
  task automatic send(input logic [31:0] nc, input logic [63:0] cand,
                      input logic [63:0] tg, input bit keep);
    for (int w = 1; w < 16; w++) hash[w*32 +: 32] = $urandom;
    hash[63:0] = cand;
    nonce      = nc;
    target     = tg;
    hash_vld   = 1'b1;
    if (cand <= tg && keep) exp_q.push_back(nc - OFFS);
    exp_count = exp_count + 32'd1;
    tick(1);
    hash_vld = 1'b0;
    nonce    = $urandom;
    target   = {$urandom, $urandom};
    tick(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_q.delete();
    exp_count = 32'd0;
  endtask

  initial begin
    reset = 1'b1; hash = '0; hash_vld = 1'b0; nonce = 32'd0;
    target = 64'd0; out_ready = 1'b0; exp_count = 32'd0;
    tick(2);
    reset = 1'b0;

    // Idle after reset: nothing rises
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b0) chk("idle_valid", {63'd0, out_valid}, 64'd0);
      tick(1);
    end
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_nonce", {32'd0, out_nonce}, 64'd0);
    chk("rst_count", {32'd0, hash_count}, 64'd0);
    chk("rst_ovf",   {63'd0, overflow}, 64'd0);

    // Single match with exact latency profile
    out_ready = 1'b1;
    hash[63:0] = 64'h1234; nonce = 32'h100; target = 64'hFF_FFFF;
    hash_vld = 1'b1; exp_q.push_back(32'h100 - OFFS); exp_count = exp_count + 32'd1;
    tick(1);                       // after edge T
    hash_vld = 1'b0;
    chk("lat_t0_valid", {63'd0, out_valid}, 64'd0);
    tick(1);                       // after edge T+1
    chk("lat_t1_valid", {63'd0, out_valid}, 64'd0);
    chk("lat_count", {32'd0, hash_count}, {32'd0, exp_count});
    tick(1);                       // after edge T+2
    chk("lat_t2_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_t2_nonce", {32'd0, out_nonce}, {32'd0, 32'h100 - OFFS});
    tick(1);                       // after edge T+3 (popped)
    chk("lat_t3_valid", {63'd0, out_valid}, 64'd0);

    // Equality matches, one-above misses
    send(32'h0000_2000, 64'h10, 64'h10, 1'b1);
    tick(3);
    chk("eq_drained", exp_q.size(), 64'd0);
    send(32'h0000_3000, 64'h11, 64'h10, 1'b1);
    tick(3);
    chk("miss_valid", {63'd0, out_valid}, 64'd0);
    chk("miss_count", {32'd0, hash_count}, {32'd0, exp_count});
    send(32'h0000_4000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    send(32'h0000_5000, 64'h0, 64'h0, 1'b1);

    // Nonce wrap below zero
    send(32'h0000_0010, 64'h5, 64'h6, 1'b1);
    send(32'h0000_0000, 64'h7, 64'h7, 1'b1);
    tick(3);
    chk("wrap_drained", exp_q.size(), 64'd0);
    chk("wrap_count", {32'd0, hash_count}, {32'd0, exp_count});

    // Overflow: 6 matches with out_ready low, the last two are dropped
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(32'h1000 + 32'(i * 7), 64'd1, 64'd9, i < DEPTH);
    tick(3);
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("ovf_valid", {63'd0, out_valid}, 64'd1);
    chk("ovf_head", {32'd0, out_nonce}, {32'd0, 32'h1000 - OFFS});
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", {63'd0, out_valid}, 64'd1);
      tick(1);
    end
    chk("drain_empty_valid", {63'd0, out_valid}, 64'd0);
    chk("drain_sb", exp_q.size(), 64'd0);
    chk("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Full FIFO with push and pop on the same edge
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(32'h2000 + 32'(i), 64'd3, 64'd3, 1'b1);
    tick(2);
    hash[63:0] = 64'd2; nonce = 32'h2ABC; target = 64'd4;
    hash_vld = 1'b1; exp_q.push_back(32'h2ABC - OFFS); exp_count = exp_count + 32'd1;
    tick(1);                       // edge T samples the hash
    hash_vld  = 1'b0;
    out_ready = 1'b1;
    tick(1);                       // edge T+1: push and pop together
    out_ready = 1'b0;
    tick(2);
    chk("fullpp_ovf", {63'd0, overflow}, 64'd0);
    chk("fullpp_sb", exp_q.size(), 64'd4);
    out_ready = 1'b1;
    tick(6);
    chk("fullpp_drained", exp_q.size(), 64'd0);
    chk("fullpp_count", {32'd0, hash_count}, {32'd0, exp_count});

    // Reset with entries queued
    out_ready = 1'b0;
    send(32'h3000, 64'd1, 64'd1, 1'b1);
    send(32'h3001, 64'd1, 64'd1, 1'b1);
    tick(2);
    chk("prerst_valid", {63'd0, out_valid}, 64'd1);
    do_reset();
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_ovf",   {63'd0, overflow}, 64'd0);
    chk("midrst_count", {32'd0, hash_count}, 64'd0);
    out_ready = 1'b1;
    tick(4);
    chk("postrst_valid", {63'd0, out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
